// File: rtl/sp_link_ctrl.sv
// Receive-side link controller: brings the link up, qualifies converter bytes and forwards payload to a FIFO.
// Optional statistics counters (err_cnt/drop_cnt) are built only when SP_LINK_STATS_EN is defined.
module sp_link_ctrl #(
  parameter logic [7:0] IDLE_BYTE = 8'hBC,
  parameter int         TRAIN_CNT = 4,
  parameter int         ERR_LIMIT = 3,
  parameter int         CNT_W     = 8
) (
  input  logic             clk_4f,
  input  logic             reset_L,
  input  logic             enable,
  input  logic [7:0]       data_in,
  input  logic             valid_in,
  input  logic             active_in,
  input  logic             fifo_full,
  output logic [7:0]       data_out,
  output logic             push,
  output logic             link_up,
  output logic [2:0]       state,
  output logic             realign,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_ACT = 3'd1;
  localparam logic [2:0] ST_TRAIN    = 3'd2;
  localparam logic [2:0] ST_LINK_UP  = 3'd3;
  localparam logic [2:0] ST_ERROR    = 3'd4;

  localparam logic [3:0] TRAIN_LAST = 4'(TRAIN_CNT - 1);
  localparam logic [3:0] ERR_LAST   = 4'(ERR_LIMIT - 1);

  logic [2:0] state_r;
  logic [2:0] state_nxt_s;
  logic [3:0] run_r;
  logic [3:0] cerr_r;
  logic [7:0] data_out_r;
  logic       push_r;
  logic       link_up_r;
  logic       realign_r;

  logic idle_ok_s;
  logic bad_idle_s;
  logic in_link_s;
  logic push_s;
  logic err_s;
  logic link_up_s;
  logic realign_s;

  assign idle_ok_s  = !valid_in && (data_in == IDLE_BYTE);
  assign bad_idle_s = !valid_in && (data_in != IDLE_BYTE);

  // State register.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; enable=0 overrides everything, lock loss overrides the error limit.
  always_comb begin
    state_nxt_s = state_r;
    if (!enable) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:     state_nxt_s = ST_WAIT_ACT;
        ST_WAIT_ACT: state_nxt_s = active_in ? ST_TRAIN : ST_WAIT_ACT;
        ST_TRAIN: begin
          if (!active_in) begin
            state_nxt_s = ST_WAIT_ACT;
          end else if (idle_ok_s && (run_r == TRAIN_LAST)) begin
            state_nxt_s = ST_LINK_UP;
          end else begin
            state_nxt_s = ST_TRAIN;
          end
        end
        ST_LINK_UP: begin
          if (!active_in) begin
            state_nxt_s = ST_WAIT_ACT;
          end else if (bad_idle_s && (cerr_r == ERR_LAST)) begin
            state_nxt_s = ST_ERROR;
          end else begin
            state_nxt_s = ST_LINK_UP;
          end
        end
        ST_ERROR:    state_nxt_s = ST_WAIT_ACT;
        default:     state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Output decode; bytes are only qualified while the link stays up this cycle.
  always_comb begin
    in_link_s = 1'b0;
    if ((state_r == ST_LINK_UP) && enable && active_in) begin
      in_link_s = 1'b1;
    end else begin
      in_link_s = 1'b0;
    end
    push_s    = in_link_s && valid_in && !fifo_full;
    err_s     = in_link_s && bad_idle_s;
    link_up_s = (state_nxt_s == ST_LINK_UP);
    realign_s = (state_nxt_s == ST_ERROR);
  end

  // Registered outputs and the training/consecutive-error run counters.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      data_out_r <= 8'd0;
      push_r     <= 1'b0;
      link_up_r  <= 1'b0;
      realign_r  <= 1'b0;
      run_r      <= 4'd0;
      cerr_r     <= 4'd0;
    end else begin
      data_out_r <= data_in;
      push_r     <= push_s;
      link_up_r  <= link_up_s;
      realign_r  <= realign_s;
      if ((state_r == ST_TRAIN) && enable && active_in && idle_ok_s) begin
        run_r <= run_r + 4'd1;
      end else begin
        run_r <= 4'd0;
      end
      if (err_s) begin
        cerr_r <= cerr_r + 4'd1;
      end else if (in_link_s && idle_ok_s) begin
        cerr_r <= 4'd0;
      end else if (state_r != ST_LINK_UP) begin
        cerr_r <= 4'd0;
      end else begin
        cerr_r <= cerr_r;
      end
    end
  end

`ifdef SP_LINK_STATS_EN
  logic [CNT_W-1:0] err_cnt_r;
  logic [CNT_W-1:0] drop_cnt_r;
  logic             drop_s;

  assign drop_s = in_link_s && valid_in && fifo_full;

  // Saturating statistics counters, cleared only by reset.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      err_cnt_r  <= '0;
      drop_cnt_r <= '0;
    end else begin
      if (err_s && (err_cnt_r != {CNT_W{1'b1}})) begin
        err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        err_cnt_r <= err_cnt_r;
      end
      if (drop_s && (drop_cnt_r != {CNT_W{1'b1}})) begin
        drop_cnt_r <= drop_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  assign err_cnt  = err_cnt_r;
  assign drop_cnt = drop_cnt_r;
`else
  assign err_cnt  = '0;
  assign drop_cnt = '0;
`endif

  assign data_out = data_out_r;
  assign push     = push_r;
  assign link_up  = link_up_r;
  assign state    = state_r;
  assign realign  = realign_r;

endmodule

// File: tb/tb_sp_link_ctrl.sv
// Directed, table-driven bench for sp_link_ctrl; counter expectations follow SP_LINK_STATS_EN.
module tb_sp_link_ctrl;

  logic       clk_4f = 1'b0;
  logic       reset_L;
  logic       enable;
  logic [7:0] data_in;
  logic       valid_in;
  logic       active_in;
  logic       fifo_full;
  logic [7:0] data_out;
  logic       push;
  logic       link_up;
  logic [2:0] state;
  logic       realign;
  logic [7:0] err_cnt;
  logic [7:0] drop_cnt;

  int total = 0;
  int bad   = 0;

  sp_link_ctrl dut (
    .clk_4f(clk_4f), .reset_L(reset_L), .enable(enable), .data_in(data_in),
    .valid_in(valid_in), .active_in(active_in), .fifo_full(fifo_full),
    .data_out(data_out), .push(push), .link_up(link_up), .state(state),
    .realign(realign), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk_4f = ~clk_4f;

  typedef struct {
    logic       en, act, v, full;
    logic [7:0] d;
    logic [2:0] st;
    logic       lk, ps;
    logic [7:0] dout;
    logic       ra;
    logic [7:0] ec, dc;
    bit         cc;
  } vec_t;

  vec_t vq[$];

  function automatic logic [7:0] cnt_exp(input int v);
`ifdef SP_LINK_STATS_EN
    return 8'(v);
`else
    return 8'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic en, act, v, full, input logic [7:0] d, input logic [2:0] st,
                     input logic lk, ps, input logic [7:0] dout, input logic ra,
                     input int ec, input int dc, input bit cc);
    vec_t r;
    r.en = en; r.act = act; r.v = v; r.full = full; r.d = d; r.st = st;
    r.lk = lk; r.ps = ps; r.dout = dout; r.ra = ra;
    r.ec = cnt_exp(ec); r.dc = cnt_exp(dc); r.cc = cc;
    vq.push_back(r);
  endtask

  task automatic step(input logic en, act, v, full, input logic [7:0] d);
    enable = en; active_in = act; valid_in = v; fifo_full = full; data_in = d;
    @(posedge clk_4f);
    #1;
  endtask

  initial begin
    reset_L = 1'b0; enable = 1'b0; active_in = 1'b0; valid_in = 1'b0;
    fifo_full = 1'b0; data_in = 8'h00;

    //   en    act   v     full  d      st    lk    ps    dout   ra    ec dc cc
    // bring-up
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'hBC, 3'd2, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'hBC, 3'd2, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'hBC, 3'd2, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'hBC, 3'd3, 1'b1, 1'b0, 8'h00, 1'b0, 0, 0, 1'b1);
    // payload, backpressure
    add(1'b1, 1'b1, 1'b1, 1'b0, 8'h11, 3'd3, 1'b1, 1'b1, 8'h11, 1'b0, 0, 0, 1'b1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 8'h22, 3'd3, 1'b1, 1'b1, 8'h22, 1'b0, 0, 0, 1'b1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 8'h33, 3'd3, 1'b1, 1'b1, 8'h33, 1'b0, 0, 0, 1'b1);
    add(1'b1, 1'b1, 1'b1, 1'b1, 8'h44, 3'd3, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'hBC, 3'd3, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1, 1'b1);
    // error limit
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd3, 1'b1, 1'b0, 8'h00, 1'b0, 1, 1, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd3, 1'b1, 1'b0, 8'h00, 1'b0, 2, 1, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0, 8'h00, 1'b1, 3, 1, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'hBC, 3'd1, 1'b0, 1'b0, 8'h00, 1'b0, 3, 1, 1'b1);
    // relink, then lock loss with a valid byte
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0, 8'h00, 1'b0, 3, 1, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'hBC, 3'd2, 1'b0, 1'b0, 8'h00, 1'b0, 3, 1, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'hBC, 3'd2, 1'b0, 1'b0, 8'h00, 1'b0, 3, 1, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'hBC, 3'd2, 1'b0, 1'b0, 8'h00, 1'b0, 3, 1, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'hBC, 3'd3, 1'b1, 1'b0, 8'h00, 1'b0, 3, 1, 1'b1);
    add(1'b1, 1'b0, 1'b1, 1'b0, 8'h55, 3'd1, 1'b0, 1'b0, 8'h00, 1'b0, 3, 1, 1'b1);
    // disable in TRAIN
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0, 8'h00, 1'b0, 3, 1, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'hBC, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 3, 1, 1'b1);
    // training run broken by a non-idle byte (valid BC) restarts the count
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0, 8'h00, 1'b0, 3, 1, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0, 8'h00, 1'b0, 3, 1, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'hBC, 3'd2, 1'b0, 1'b0, 8'h00, 1'b0, 3, 1, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'hBC, 3'd2, 1'b0, 1'b0, 8'h00, 1'b0, 3, 1, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'hBC, 3'd2, 1'b0, 1'b0, 8'h00, 1'b0, 3, 1, 1'b1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 8'hBC, 3'd2, 1'b0, 1'b0, 8'h00, 1'b0, 3, 1, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'hBC, 3'd2, 1'b0, 1'b0, 8'h00, 1'b0, 3, 1, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'hBC, 3'd2, 1'b0, 1'b0, 8'h00, 1'b0, 3, 1, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'hBC, 3'd2, 1'b0, 1'b0, 8'h00, 1'b0, 3, 1, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'hBC, 3'd3, 1'b1, 1'b0, 8'h00, 1'b0, 3, 1, 1'b1);
    // lock loss wins over reaching the error limit
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd3, 1'b1, 1'b0, 8'h00, 1'b0, 4, 1, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd3, 1'b1, 1'b0, 8'h00, 1'b0, 5, 1, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0, 8'h00, 1'b0, 5, 1, 1'b0);

    // reset state
    repeat (2) @(posedge clk_4f);
    #1;
    chk("rst_state", {5'd0, state}, 8'd0);
    chk("rst_push", {7'd0, push}, 8'd0);
    chk("rst_link", {7'd0, link_up}, 8'd0);
    chk("rst_realign", {7'd0, realign}, 8'd0);
    chk("rst_dout", data_out, 8'd0);
    chk("rst_err", err_cnt, 8'd0);
    chk("rst_drop", drop_cnt, 8'd0);
    reset_L = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].en, vq[i].act, vq[i].v, vq[i].full, vq[i].d);
      chk($sformatf("v%0d_state", i), {5'd0, state}, {5'd0, vq[i].st});
      chk($sformatf("v%0d_link", i), {7'd0, link_up}, {7'd0, vq[i].lk});
      chk($sformatf("v%0d_push", i), {7'd0, push}, {7'd0, vq[i].ps});
      chk($sformatf("v%0d_realign", i), {7'd0, realign}, {7'd0, vq[i].ra});
      if (vq[i].ps) chk($sformatf("v%0d_dout", i), data_out, vq[i].dout);
      if (vq[i].cc) begin
        chk($sformatf("v%0d_err", i), err_cnt, vq[i].ec);
        chk($sformatf("v%0d_drop", i), drop_cnt, vq[i].dc);
      end
    end

    // drop counter saturation: relink and drop 260 more bytes
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 8'hBC);
    chk("relink_state", {5'd0, state}, 8'd3);
    for (int k = 0; k < 260; k++) step(1'b1, 1'b1, 1'b1, 1'b1, 8'(k));
    chk("sat_drop", drop_cnt, cnt_exp(255));
    chk("sat_state", {5'd0, state}, 8'd3);
    chk("sat_push", {7'd0, push}, 8'd0);

    // asynchronous reset while a push is on the outputs
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h66);
    chk("pre_rst_push", {7'd0, push}, 8'd1);
    chk("pre_rst_dout", data_out, 8'h66);
    reset_L = 1'b0;
    #1;
    chk("async_push", {7'd0, push}, 8'd0);
    chk("async_state", {5'd0, state}, 8'd0);
    chk("async_link", {7'd0, link_up}, 8'd0);
    chk("async_dout", data_out, 8'd0);
    chk("async_err", err_cnt, 8'd0);
    chk("async_drop", drop_cnt, 8'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("held_rst_state", {5'd0, state}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
